// File: rtl/ibex_instr_realigner.sv
// Realigns word-aligned fetch words into 16/32-bit instructions with PC tracking.
// One cycle from push to output (no bypass); in_ready_o is registered-only, out_* hold under stall.
module ibex_instr_realigner #(
  parameter int unsigned DEPTH = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_addr_i,
  input  logic [31:0] in_rdata_i,
  input  logic        in_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_addr_o,
  output logic [31:0] out_rdata_o,
  output logic        out_err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]      rdata_q [DEPTH];
  logic [31:0]      rdata_d [DEPTH];
  logic [DEPTH-1:0] err_q;
  logic [DEPTH-1:0] err_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [CW-1:0]    wr_idx;
  logic [31:0]      pc_q;
  logic [31:0]      pc_d;

  logic        e0v;
  logic        e1v;
  logic [31:0] w0;
  logic [15:0] w1_lo;
  logic        w0_err;
  logic        w1_err;
  logic        off;
  logic [15:0] half;
  logic        comp;
  logic        push;
  logic        pop;
  logic        hs;

  // Invalid entries read as zero so idle outputs are all-zero after reset.
  assign e0v    = (count_q != '0);
  assign e1v    = (count_q > CW'(1));
  assign w0     = e0v ? rdata_q[0] : 32'h0;
  assign w1_lo  = e1v ? rdata_q[1][15:0] : 16'h0;
  assign w0_err = e0v & err_q[0];
  assign w1_err = e1v & err_q[1];

  assign off  = pc_q[1];
  assign half = off ? w0[31:16] : w0[15:0];
  assign comp = (half[1:0] != 2'b11);

  assign in_ready_o  = (count_q < DEPTH_C);
  assign out_valid_o = !clear_i & e0v & (comp | !off | e1v | w0_err);
  assign out_addr_o  = pc_q;
  assign out_err_o   = w0_err | (!comp & off & e1v & w1_err);

  always_comb begin
    out_rdata_o = {16'h0000, half};
    if (!comp && !off) begin
      out_rdata_o = w0;
    end else if (!comp && off && e1v && !w0_err) begin
      out_rdata_o = {w1_lo, w0[31:16]};
    end
  end

  // An aligned compressed instruction leaves the upper half of w0 still pending.
  assign hs     = out_valid_o & out_ready_i;
  assign pop    = hs & !(comp & !off);
  assign push   = in_valid_i & in_ready_o & !clear_i;
  assign wr_idx = count_q - {{(CW-1){1'b0}}, pop};

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rdata_d[i] = rdata_q[i];
      err_d[i]   = err_q[i];
    end
    count_d = count_q;
    pc_d    = pc_q;

    if (clear_i) begin
      count_d = '0;
      pc_d    = in_addr_i & 32'hFFFF_FFFE;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          rdata_d[i] = rdata_q[i+1];
          err_d[i]   = err_q[i+1];
        end
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == CW'(i))) begin
          rdata_d[i] = in_rdata_i;
          err_d[i]   = in_err_i;
        end
      end
      count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      if (hs) begin
        pc_d = pc_q + (comp ? 32'd2 : 32'd4);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rdata_q[i] <= 32'h0;
      end
      err_q   <= '0;
      count_q <= '0;
      pc_q    <= 32'h0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rdata_q[i] <= rdata_d[i];
      end
      err_q   <= err_d;
      count_q <= count_d;
      pc_q    <= pc_d;
    end
  end

endmodule

// File: tb/tb_ibex_instr_realigner.sv
// Bench for ibex_instr_realigner: directed table, corner sequences, random vs halfword-stream model.
module tb_ibex_instr_realigner;

  localparam int DEPTH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_rdata;
  logic        in_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_rdata;
  logic        out_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ibex_instr_realigner #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_addr_i   (in_addr),
    .in_rdata_i  (in_rdata),
    .in_err_i    (in_err),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_addr_o  (out_addr),
    .out_rdata_o (out_rdata),
    .out_err_o   (out_err)
  );

  // Reference: queue of fetch words plus PC; instructions are read as a halfword stream.
  typedef struct {
    logic [31:0] d;
    logic        e;
  } word_t;

  word_t       mq[$];
  logic [31:0] mpc;

  typedef struct {
    logic        clr;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] d;
    logic        e;
    logic        ordy;
    logic        xv;
    logic [31:0] xd;
    logic [31:0] xa;
    logic        xe;
    logic        xir;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic clr, input logic [31:0] addr, input logic iv,
                              input logic [31:0] d, input logic e, input logic ordy,
                              input logic xv, input logic [31:0] xd, input logic [31:0] xa,
                              input logic xe, input logic xir);
    vec_t r;
    r.clr = clr; r.addr = addr; r.iv = iv; r.d = d; r.e = e; r.ordy = ordy;
    r.xv = xv; r.xd = xd; r.xa = xa; r.xe = xe; r.xir = xir;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected output and number of halfwords the presented instruction consumes.
  function automatic void m_out(input logic clr, output logic v, output logic [31:0] d,
                                output logic e, output int n);
    logic [15:0] hh[$];
    logic        he[$];
    logic        off;
    v = 1'b0; d = 32'h0; e = 1'b0; n = 0;
    off = mpc[1];
    foreach (mq[i]) begin
      if (!(i == 0 && off)) begin
        hh.push_back(mq[i].d[15:0]);
        he.push_back(mq[i].e);
      end
      hh.push_back(mq[i].d[31:16]);
      he.push_back(mq[i].e);
    end
    if (hh.size() == 0) return;
    if (hh[0][1:0] != 2'b11) begin
      v = 1'b1; d = {16'h0, hh[0]}; e = he[0]; n = 1;
    end else if (he[0] && off) begin
      v = 1'b1; d = {16'h0, hh[0]}; e = 1'b1; n = 2;
    end else if (hh.size() >= 2) begin
      v = 1'b1; d = {hh[1], hh[0]}; e = he[0] | he[1]; n = 2;
    end
    if (clr) v = 1'b0;
  endfunction

  task automatic model_check(input logic clr);
    logic        v;
    logic [31:0] d;
    logic        e;
    int          n;
    m_out(clr, v, d, e, n);
    chk("m_in_ready", {31'h0, in_ready}, {31'h0, (mq.size() < DEPTH)});
    chk("m_out_valid", {31'h0, out_valid}, {31'h0, v});
    chk("m_out_addr", out_addr, mpc);
    if (v) begin
      chk("m_out_rdata", out_rdata, d);
      chk("m_out_err", {31'h0, out_err}, {31'h0, e});
    end
  endtask

  task automatic model_step(input logic c, input logic [31:0] a, input logic v,
                            input logic [31:0] d, input logic e, input logic r);
    logic        ov;
    logic [31:0] od;
    logic        oe;
    int          n;
    bit          acc;
    word_t       w;
    if (c) begin
      mq.delete();
      mpc = {a[31:1], 1'b0};
      return;
    end
    m_out(1'b0, ov, od, oe, n);
    acc = v && (mq.size() < DEPTH);
    if (ov && r) begin
      if (((int'(mpc[1]) + n) / 2) == 1) void'(mq.pop_front());
      mpc = mpc + 32'(2 * n);
    end
    if (acc) begin
      w.d = d; w.e = e;
      mq.push_back(w);
    end
  endtask

  task automatic cyc(input logic c, input logic [31:0] a, input logic v, input logic [31:0] d,
                     input logic e, input logic r, input bit mcheck);
    @(posedge clk);
    #1;
    clear = c; in_addr = a; in_valid = v; in_rdata = d; in_err = e; out_ready = r;
    @(negedge clk);
    if (mcheck) model_check(c);
    model_step(c, a, v, d, e, r);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
    if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_addr = 32'h0;
    in_rdata = 32'h0; in_err = 1'b0; out_ready = 1'b0;
    mpc = 32'h0;
    #23 rst_n = 1'b1;

    // clr addr iv data e ordy | valid rdata addr err in_ready
    tbl[0]  = mk(0, 0,     0, 0,            0, 0, 0, 32'h0,      32'h0,   0, 1);
    tbl[1]  = mk(0, 0,     1, 32'h00000013, 0, 0, 0, 32'h0,      32'h0,   0, 1);
    tbl[2]  = mk(0, 0,     0, 0,            0, 1, 1, 32'h13,     32'h0,   0, 1);
    tbl[3]  = mk(0, 0,     0, 0,            0, 0, 0, 32'h0,      32'h4,   0, 1);
    tbl[4]  = mk(1, 32'h100, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0,    32'h4,   0, 1);
    tbl[5]  = mk(0, 0,     1, 32'h45014505, 0, 0, 0, 32'h0,      32'h100, 0, 1);
    tbl[6]  = mk(0, 0,     0, 0,            0, 1, 1, 32'h4505,   32'h100, 0, 1);
    tbl[7]  = mk(0, 0,     0, 0,            0, 1, 1, 32'h4501,   32'h102, 0, 1);
    tbl[8]  = mk(0, 0,     0, 0,            0, 0, 0, 32'h0,      32'h104, 0, 1);
    tbl[9]  = mk(1, 32'h202, 0, 0,          0, 0, 0, 32'h0,      32'h104, 0, 1);
    tbl[10] = mk(0, 0,     1, 32'h05134505, 0, 0, 0, 32'h0,      32'h202, 0, 1);
    tbl[11] = mk(0, 0,     1, 32'hABCD0000, 0, 1, 0, 32'h0,      32'h202, 0, 1);
    tbl[12] = mk(0, 0,     0, 0,            0, 1, 1, 32'h0513,   32'h202, 0, 1);
    tbl[13] = mk(0, 0,     0, 0,            0, 1, 1, 32'hABCD,   32'h206, 0, 1);
    tbl[14] = mk(0, 0,     0, 0,            0, 0, 0, 32'h0,      32'h208, 0, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].clr, tbl[i].addr, tbl[i].iv, tbl[i].d, tbl[i].e, tbl[i].ordy, 1'b0);
      chk($sformatf("tbl%0d_valid", i), {31'h0, out_valid}, {31'h0, tbl[i].xv});
      chk($sformatf("tbl%0d_addr", i), out_addr, tbl[i].xa);
      chk($sformatf("tbl%0d_ready", i), {31'h0, in_ready}, {31'h0, tbl[i].xir});
      if (tbl[i].xv || i == 0) begin
        chk($sformatf("tbl%0d_rdata", i), out_rdata, tbl[i].xd);
        chk($sformatf("tbl%0d_err", i), {31'h0, out_err}, {31'h0, tbl[i].xe});
      end
    end

    // Unaligned uncompressed with error on w0: presented without w1, held when w1 arrives.
    cyc(1, 32'h302, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h55531111, 1, 0, 1);
    cyc(0, 0, 1, 32'h77778888, 0, 0, 1);
    chk("err_valid", {31'h0, out_valid}, 32'h1);
    chk("err_err", {31'h0, out_err}, 32'h1);
    chk("err_rdata", out_rdata, 32'h00005553);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("err_hold_rdata", out_rdata, 32'h00005553);
    chk("err_hold_err", {31'h0, out_err}, 32'h1);
    chk("err_hold_addr", out_addr, 32'h302);
    cyc(0, 0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("err_after_valid", {31'h0, out_valid}, 32'h0);
    chk("err_after_addr", out_addr, 32'h306);

    // Fill to DEPTH, then push+pop while full and just below full.
    cyc(1, 32'h0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 32'h10000003 + 32'(16 * i), 0, 0, 1);
    cyc(0, 0, 1, 32'h20000003, 0, 1, 1);
    chk("full_in_ready", {31'h0, in_ready}, 32'h0);
    chk("full_rdata0", out_rdata, 32'h10000003);
    cyc(0, 0, 1, 32'h20000003, 0, 1, 1);
    chk("full_in_ready2", {31'h0, in_ready}, 32'h1);
    chk("full_rdata1", out_rdata, 32'h10000013);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("full_rdata2", out_rdata, 32'h10000023);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("full_rdata3", out_rdata, 32'h20000003);
    chk("full_addr3", out_addr, 32'hC);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("full_drained", {31'h0, out_valid}, 32'h0);

    // Clear beats a same-cycle push and handshake.
    cyc(1, 32'h600, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h00000013, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("clr_pre_valid", {31'h0, out_valid}, 32'h1);
    cyc(1, 32'h503, 1, 32'hFFFFFFFF, 0, 1, 1);
    chk("clr_valid", {31'h0, out_valid}, 32'h0);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("clr_post_valid", {31'h0, out_valid}, 32'h0);
    chk("clr_post_addr", out_addr, 32'h502);
    chk("clr_post_ready", {31'h0, in_ready}, 32'h1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom, ($urandom_range(0, 9) < 6), rand_word(),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6), 1'b1);
    end

    // Asynchronous reset in mid-stream.
    cyc(1, 32'h700, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 32'h45014505, 0, 0, 1);
    cyc(0, 0, 1, 32'h00000013, 0, 0, 1);
    chk("rst_pre_valid", {31'h0, out_valid}, 32'h1);
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_addr", out_addr, 32'h0);
    chk("rst_rdata", out_rdata, 32'h0);
    chk("rst_err", {31'h0, out_err}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    mq.delete();
    mpc = 32'h0;
    for (int k = 0; k < 100; k++) begin
      cyc(($urandom_range(0, 39) == 0), $urandom, ($urandom_range(0, 9) < 6), rand_word(),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) < 6), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_instr_realigner.md
Name: ibex_instr_realigner

Overview:
- Fetch-side realignment buffer directly upstream of the compressed decoder.
- Accepts word-aligned 32-bit fetch words from the instruction memory interface and buffers them in a small FIFO.
- Emits one instruction per valid/ready handshake: either a 16-bit compressed instruction or a 32-bit instruction, including 32-bit instructions that straddle two fetch words.
- Tracks the PC of the instruction it presents; a clear reloads that PC from a branch/jump target.

Parameters:
- DEPTH, 3, number of 32-bit FIFO entries (minimum 2).

Ports:
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- clear_i  input  1  flush all entries; load PC from in_addr_i
- in_valid_i  input  1  fetch word valid
- in_ready_o  output  1  FIFO can accept a word this cycle
- in_addr_i  input  32  on clear_i: new PC (bit 1 may be set); otherwise ignored
- in_rdata_i  input  32  fetch word
- in_err_i  input  1  bus error on this fetch word
- out_valid_o  output  1  instruction available
- out_ready_i  input  1  consumer (compressed decoder stage) accepts
- out_addr_o  output  32  PC of presented instruction
- out_rdata_o  output  32  instruction bits
- out_err_o  output  1  fetch error associated with presented instruction

Behaviour:
- Reset (async, rst_ni=0): count=0, pc_q=0, all entries invalid. Outputs: out_valid_o=0, out_err_o=0, out_rdata_o=0, out_addr_o=0, in_ready_o=1.
- Storage: DEPTH entries of {rdata[31:0], err}. Entry 0 is the head. Count width is clog2(DEPTH+1).
- in_ready_o = (count < DEPTH). It depends on registered state only, never on out_ready_i.
- Push: in_valid_i & in_ready_o & !clear_i. The word is written at index count (after any same-cycle pop shift).
- Latency: a pushed word is visible to the output logic the next cycle. There is no combinational in-to-out bypass.
- Definitions: w0/w1 = entries 0/1. off = pc_q[1]. half = off ? w0[31:16] : w0[15:0]. comp = (half[1:0] != 2'b11).
- out_valid_o = !clear_i & entry0 valid & (comp | !off | entry1 valid | w0.err).
- out_rdata_o:
  - comp: {16'h0000, half}
  - !comp & !off: w0
  - !comp & off & entry1 valid & !w0.err: {w1[15:0], w0[31:16]}
  - !comp & off & w0.err: {16'h0000, half}
- out_err_o = w0.err | (!comp & off & entry1 valid & w1.err).
- out_addr_o = pc_q.
- Handshake (out_valid_o & out_ready_i):
  - aligned, compressed: no pop; pc_q += 2 (off becomes 1)
  - aligned, uncompressed: pop 1; pc_q += 4
  - unaligned, compressed: pop 1; pc_q += 2 (off becomes 0)
  - unaligned, uncompressed: pop 1; pc_q += 4 (off stays 1; the upper half of the old w1 becomes the next half)
- pc_q arithmetic is 32-bit modulo 2^32 (wraps 0xFFFFFFFE -> 0x00000000).
- Stability: while out_valid_o=1 and out_ready_i=0, out_rdata_o, out_addr_o and out_err_o hold. This holds even when a new word is pushed, including in the w0.err unaligned case.
- Simultaneous push and pop: allowed; count is unchanged. When full, a push is permitted only via in_ready_o, so with count==DEPTH no push occurs even if a pop happens the same cycle.
- clear_i (priority over push and pop): count <= 0; pc_q <= {in_addr_i[31:1], 1'b0}; the same-cycle push is discarded; out_valid_o is forced 0.
- Reset asserted mid-operation: immediate return to reset state; no partial output.
- pc_q[0] is always 0.

Test Plan:
- Reset, then push 0x00000013 (ADDI, aligned) -> next cycle out_valid_o=1, out_rdata_o=0x00000013, out_addr_o=0; after accept, pc=4, count=0.
- clear_i with in_addr_i=0x100, push 0x4501_4505 -> out 0x00004505 @0x100, then 0x00004501 @0x102; one pop total; pc=0x104.
- clear_i with in_addr_i=0x202, push 0x0513_4505, then 0xABCD_0000 -> first out 0x00000513? No: half=0x0513, bits[1:0]=11, so out_valid_o stays 0 until second word; then out_rdata_o=0x00000513 | (0x0000<<16)=0x00000513 @0x202, pc -> 0x206.
- Unaligned uncompressed with w0.err=1 and no w1 -> out_valid_o=1, out_err_o=1, out_rdata_o={16'h0, half}; outputs hold when w1 is later pushed while out_ready_i=0.
- Fill DEPTH words with out_ready_i=0 -> in_ready_o=0 at count=DEPTH. Assert in_valid_i and out_ready_i together on 32-bit aligned words -> exactly one pop and one push accepted only when in_ready_o=1; data order preserved.
- clear_i asserted in the same cycle as in_valid_i and an output handshake -> no push, no pop effect, out_valid_o=0, pc_q=new target, count=0; rst_ni pulse mid-stream -> all outputs return to reset values asynchronously.
